// File: rtl/rv_branch_pkg.sv
// Shared condition codes and 2-bit predictor state for the branch predictor slice.
// Pure declarations: no logic, no latency, no backpressure.
package rv_branch_pkg;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_state_e;

    // Saturating up/down step of the 2-bit counter.
    function automatic bp_state_e bp_next_state(input bp_state_e s, input logic taken);
        bp_state_e n;
        n = s;
        if (taken) begin
            if (s != ST) n = bp_state_e'(s + 2'd1);
        end else begin
            if (s != SNT) n = bp_state_e'(s - 2'd1);
        end
        return n;
    endfunction

endpackage

// File: rtl/rv_branch_cond.sv
// Branch condition evaluator: ALU flags x condition code -> holds / code defined.
// Purely combinational, zero latency, no backpressure.
module rv_branch_cond
    import rv_branch_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       holds_o,
    output logic       defined_o
);

    logic neg, zero, carry, ovf;
    assign {neg, zero, carry, ovf} = flags_i;

    always_comb begin
        holds_o   = 1'b0;
        defined_o = 1'b1;
        case (cond_i)
            COND_EQ: holds_o = zero;
            COND_NE: holds_o = ~zero;
            COND_CS: holds_o = carry;
            COND_CC: holds_o = ~carry;
            COND_GE: holds_o = (neg == ovf);
            COND_LT: holds_o = (neg != ovf);
            default: defined_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_branch_pred.sv
// BTB + 2-bit predictor with execute-stage resolution; optional RV_BRANCH_PRED_PERF_EN counters.
// Lookup and resolution are combinational; table and counters update on the next clk edge; no backpressure.
module rv_branch_pred
    import rv_branch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [XLEN-1:0] PCF,
    output logic            PredTakenF,
    output logic [XLEN-1:0] PredTargetF,
    input  logic            ValidE,
    input  logic            JumpE,
    input  logic            BranchE,
    input  logic [3:0]      ALUFlags,
    input  logic [3:0]      CondE,
    input  logic [XLEN-1:0] PCE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic [XLEN-1:0] PCPlus4E,
    input  logic            PredTakenE,
    input  logic [XLEN-1:0] PredTargetE,
    output logic            MispredictE,
    output logic [XLEN-1:0] RedirectPCE,
    output logic            TakenE,
    output logic            IllegalCondE
`ifdef RV_BRANCH_PRED_PERF_EN
    ,
    input  logic            PerfClr,
    output logic [31:0]     BranchCnt,
    output logic [31:0]     MispredCnt
`endif
);

    localparam int IDXW = $clog2(DEPTH);
    localparam int TAGW = XLEN - IDXW - 2;

    logic            valid_q  [DEPTH];
    bp_state_e       state_q  [DEPTH];
    logic [TAGW-1:0] tag_q    [DEPTH];
    logic [XLEN-1:0] tgt_q    [DEPTH];
    logic            isjump_q [DEPTH];

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{PCF[1:0], PCE[1:0]};

    // Fetch-side lookup sees only registered state, so a same-index update is invisible until next cycle.
    logic [IDXW-1:0] idx_f;
    logic [TAGW-1:0] tag_f;
    logic            hit_f;
    logic [1:0]      st_f;

    assign idx_f       = PCF[IDXW+1:2];
    assign tag_f       = PCF[XLEN-1:IDXW+2];
    assign hit_f       = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
    assign st_f        = state_q[idx_f];
    assign PredTakenF  = hit_f & (isjump_q[idx_f] | st_f[1]);
    assign PredTargetF = hit_f ? tgt_q[idx_f] : '0;

    logic cond_holds, cond_defined;

    rv_branch_cond u_cond (
        .cond_i    (CondE),
        .flags_i   (ALUFlags),
        .holds_o   (cond_holds),
        .defined_o (cond_defined)
    );

    assign TakenE       = JumpE | (BranchE & cond_holds);
    assign MispredictE  = ValidE & ((TakenE != PredTakenE) |
                                    (TakenE & (PredTargetE != PCTargetE)));
    assign RedirectPCE  = TakenE ? PCTargetE : PCPlus4E;
    assign IllegalCondE = ValidE & BranchE & ~cond_defined;

    logic [IDXW-1:0] idx_e;
    logic [TAGW-1:0] tag_e;
    logic            upd_en, hit_e, state_wr, tgt_wr;
    bp_state_e       state_d;

    assign idx_e    = PCE[IDXW+1:2];
    assign tag_e    = PCE[XLEN-1:IDXW+2];
    assign upd_en   = ValidE & (BranchE | JumpE);
    assign hit_e    = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    assign state_wr = upd_en & (hit_e | TakenE);
    assign tgt_wr   = upd_en & TakenE;
    assign state_d  = hit_e ? bp_next_state(state_q[idx_e], TakenE) : WT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                state_q[i] <= WNT;
            end
        end else if (state_wr) begin
            valid_q[idx_e] <= 1'b1;
            state_q[idx_e] <= state_d;
        end
    end

    // Payload is meaningless while valid is clear, so it carries no reset.
    always_ff @(posedge clk) begin
        if (tgt_wr) begin
            tag_q[idx_e] <= tag_e;
            tgt_q[idx_e] <= PCTargetE;
            if (!hit_e) isjump_q[idx_e] <= JumpE;
        end
    end

`ifdef RV_BRANCH_PRED_PERF_EN
    logic [31:0] branch_cnt_q, mispred_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else if (PerfClr) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            if (upd_en && (branch_cnt_q != '1))       branch_cnt_q  <= branch_cnt_q + 32'd1;
            if (MispredictE && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 32'd1;
        end
    end

    assign BranchCnt  = branch_cnt_q;
    assign MispredCnt = mispred_cnt_q;
`endif

endmodule

// File: tb/tb_rv_branch_pred.sv
// Self-checking bench for rv_branch_pred: directed vectors, hand sequences and a random run vs a behavioural model.
// Default parameters (XLEN=32, DEPTH=16); perf-counter checks follow RV_BRANCH_PRED_PERF_EN.
module tb_rv_branch_pred;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] PCF, PredTargetF, PCE, PCTargetE, PCPlus4E, PredTargetE, RedirectPCE;
    logic        PredTakenF, ValidE, JumpE, BranchE, PredTakenE;
    logic        MispredictE, TakenE, IllegalCondE;
    logic [3:0]  ALUFlags, CondE;
`ifdef RV_BRANCH_PRED_PERF_EN
    logic        PerfClr;
    logic [31:0] BranchCnt, MispredCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rv_branch_pred dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .PCF          (PCF),
        .PredTakenF   (PredTakenF),
        .PredTargetF  (PredTargetF),
        .ValidE       (ValidE),
        .JumpE        (JumpE),
        .BranchE      (BranchE),
        .ALUFlags     (ALUFlags),
        .CondE        (CondE),
        .PCE          (PCE),
        .PCTargetE    (PCTargetE),
        .PCPlus4E     (PCPlus4E),
        .PredTakenE   (PredTakenE),
        .PredTargetE  (PredTargetE),
        .MispredictE  (MispredictE),
        .RedirectPCE  (RedirectPCE),
        .TakenE       (TakenE),
        .IllegalCondE (IllegalCondE)
`ifdef RV_BRANCH_PRED_PERF_EN
        ,
        .PerfClr      (PerfClr),
        .BranchCnt    (BranchCnt),
        .MispredCnt   (MispredCnt)
`endif
    );

    // Reference model: one record per BTB slot, state held as an integer 0..3.
    bit          mvalid [16];
    logic [25:0] mtag   [16];
    logic [31:0] mtgt   [16];
    bit          mjump  [16];
    int          mst    [16];
    int unsigned mbr, mmis;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0b expected=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_cond(input logic [3:0] c, input logic [3:0] f);
        // f = {neg, zero, carry, overflow}
        case (c)
            4'd0:    return f[2];
            4'd1:    return !f[2];
            4'd2:    return f[1];
            4'd3:    return !f[1];
            4'd10:   return f[3] == f[0];
            4'd11:   return f[3] != f[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit m_defined(input logic [3:0] c);
        return (c inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd10, 4'd11});
    endfunction

    function automatic bit m_taken();
        return JumpE || (BranchE && m_cond(CondE, ALUFlags));
    endfunction

    function automatic bit m_misp();
        bit t;
        t = m_taken();
        return ValidE && ((t != PredTakenE) || (t && PredTargetE != PCTargetE));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            mvalid[i] = 0;
            mst[i]    = 1;
        end
        mbr  = 0;
        mmis = 0;
    endtask

    task automatic check_all();
        int  fi;
        bit  hit, t;
        fi  = int'(PCF[5:2]);
        hit = mvalid[fi] && (mtag[fi] == PCF[31:6]);
        t   = m_taken();
        chk1("PredTakenF", PredTakenF, hit && (mjump[fi] || mst[fi] >= 2));
        chk32("PredTargetF", PredTargetF, hit ? mtgt[fi] : 32'h0);
        chk1("TakenE", TakenE, t);
        chk1("MispredictE", MispredictE, m_misp());
        chk32("RedirectPCE", RedirectPCE, t ? PCTargetE : PCPlus4E);
        chk1("IllegalCondE", IllegalCondE, ValidE && BranchE && !m_defined(CondE));
`ifdef RV_BRANCH_PRED_PERF_EN
        chk32("BranchCnt", BranchCnt, mbr);
        chk32("MispredCnt", MispredCnt, mmis);
`endif
    endtask

    task automatic model_update();
        int ei;
        bit hit, t, upd, misp;
        ei   = int'(PCE[5:2]);
        hit  = mvalid[ei] && (mtag[ei] == PCE[31:6]);
        t    = m_taken();
        upd  = ValidE && (BranchE || JumpE);
        misp = m_misp();
        if (upd) begin
            if (hit) begin
                if (t) begin
                    mst[ei]  = (mst[ei] < 3) ? mst[ei] + 1 : 3;
                    mtgt[ei] = PCTargetE;
                end else begin
                    mst[ei] = (mst[ei] > 0) ? mst[ei] - 1 : 0;
                end
            end else if (t) begin
                mvalid[ei] = 1;
                mtag[ei]   = PCE[31:6];
                mtgt[ei]   = PCTargetE;
                mjump[ei]  = JumpE;
                mst[ei]    = 2;
            end
        end
`ifdef RV_BRANCH_PRED_PERF_EN
        if (PerfClr) begin
            mbr  = 0;
            mmis = 0;
        end else begin
            if (upd && mbr != 32'hFFFF_FFFF) mbr++;
            if (misp && mmis != 32'hFFFF_FFFF) mmis++;
        end
`endif
    endtask

    // Called at/after a negedge with inputs already set; returns at the following negedge.
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        ValidE = 0; JumpE = 0; BranchE = 0; ALUFlags = 4'h0; CondE = 4'h0;
        PCE = 32'h0; PCTargetE = 32'h0; PCPlus4E = 32'h4;
        PredTakenE = 0; PredTargetE = 32'h0;
`ifdef RV_BRANCH_PRED_PERF_EN
        PerfClr = 0;
`endif
    endtask

    task automatic br(input logic [31:0] pce, input bit taken, input logic [31:0] tgt);
        idle();
        ValidE = 1; BranchE = 1; CondE = 4'b0000;
        ALUFlags = taken ? 4'b0100 : 4'b0000;
        PCE = pce; PCTargetE = tgt; PCPlus4E = pce + 32'd4; PCF = pce;
        step();
    endtask

    task automatic probe(input string name, input logic [31:0] pcf, input bit exp_t,
                         input logic [31:0] exp_tgt);
        idle();
        PCF = pcf;
        #1;
        chk1({name, ".taken"}, PredTakenF, exp_t);
        chk32({name, ".target"}, PredTargetF, exp_tgt);
    endtask

    typedef struct {
        logic        v, j, b;
        logic [3:0]  fl, cd;
        logic        pt;
        logic [31:0] ptg, tg;
        logic        et, em;
        logic [31:0] er;
        logic        ei;
    } vec_t;

    vec_t vecs [13];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        //            v  j  b  flags    cond     pt ptgt        tgt          taken misp redirect  illegal
        vecs[0]  = '{1, 0, 1, 4'b0100, 4'b0000, 0, 32'h0,      32'h300,     1, 1, 32'h300, 0};
        vecs[1]  = '{1, 0, 1, 4'b0000, 4'b0000, 0, 32'h0,      32'h300,     0, 0, 32'h208, 0};
        vecs[2]  = '{1, 0, 1, 4'b0000, 4'b0001, 1, 32'h300,    32'h300,     1, 0, 32'h300, 0};
        vecs[3]  = '{1, 0, 1, 4'b0010, 4'b0010, 1, 32'h2F0,    32'h300,     1, 1, 32'h300, 0};
        vecs[4]  = '{1, 0, 1, 4'b0010, 4'b0011, 1, 32'h300,    32'h300,     0, 1, 32'h208, 0};
        vecs[5]  = '{1, 0, 1, 4'b1001, 4'b1010, 1, 32'h300,    32'h300,     1, 0, 32'h300, 0};
        vecs[6]  = '{1, 0, 1, 4'b1000, 4'b1011, 0, 32'h0,      32'h300,     1, 1, 32'h300, 0};
        vecs[7]  = '{1, 0, 1, 4'b1111, 4'b0101, 0, 32'h0,      32'h300,     0, 0, 32'h208, 1};
        vecs[8]  = '{0, 0, 1, 4'b0100, 4'b0101, 1, 32'h0,      32'h300,     0, 0, 32'h208, 0};
        vecs[9]  = '{1, 1, 0, 4'b0000, 4'b0101, 0, 32'h0,      32'h300,     1, 1, 32'h300, 0};
        vecs[10] = '{0, 0, 1, 4'b0100, 4'b0000, 0, 32'h0,      32'h300,     1, 0, 32'h300, 0};
        vecs[11] = '{1, 0, 0, 4'b0100, 4'b0000, 1, 32'h300,    32'h300,     0, 1, 32'h208, 0};
        vecs[12] = '{1, 0, 1, 4'b1000, 4'b1010, 0, 32'h0,      32'h300,     0, 0, 32'h208, 0};

        reset_n = 0;
        PCF = 32'h0;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1;

        // Empty table after reset: nothing predicts taken.
        for (int i = 0; i < 16; i++) probe("reset", 32'(i * 4), 0, 32'h0);
        probe("reset_3c", 32'h3C, 0, 32'h0);
        step();

        // First taken branch: mispredict, redirect, then allocated as WT.
        idle();
        ValidE = 1; BranchE = 1; CondE = 4'b0000; ALUFlags = 4'b0100;
        PCE = 32'h40; PCTargetE = 32'h80; PCPlus4E = 32'h44; PCF = 32'h40;
        #1;
        chk1("alloc.mispredict", MispredictE, 1);
        chk32("alloc.redirect", RedirectPCE, 32'h80);
        chk1("alloc.same_cycle_no_bypass", PredTakenF, 0);
        step();
        probe("alloc.lookup", 32'h40, 1, 32'h80);

        // Saturation walk: WT -> ST -> WT -> WNT -> SNT -> SNT -> WNT -> WT.
        br(32'h40, 1, 32'h80); probe("sat.st", 32'h40, 1, 32'h80);
        br(32'h40, 0, 32'h80); probe("sat.nt1", 32'h40, 1, 32'h80);
        br(32'h40, 0, 32'h80); probe("sat.nt2", 32'h40, 0, 32'h80);
        br(32'h40, 0, 32'h80); probe("sat.nt3", 32'h40, 0, 32'h80);
        br(32'h40, 0, 32'h80); probe("sat.nt4", 32'h40, 0, 32'h80);
        br(32'h40, 1, 32'h80); probe("sat.t_from_snt", 32'h40, 0, 32'h80);
        br(32'h40, 1, 32'h80); probe("sat.t_again", 32'h40, 1, 32'h80);

        // 0x440 aliases 0x40 and evicts it.
        br(32'h440, 1, 32'h100);
        probe("alias.old", 32'h40, 0, 32'h0);
        probe("alias.new", 32'h440, 1, 32'h100);

        for (int k = 0; k < 13; k++) begin
            idle();
            ValidE = vecs[k].v; JumpE = vecs[k].j; BranchE = vecs[k].b;
            ALUFlags = vecs[k].fl; CondE = vecs[k].cd;
            PredTakenE = vecs[k].pt; PredTargetE = vecs[k].ptg;
            PCE = 32'h204; PCTargetE = vecs[k].tg; PCPlus4E = 32'h208; PCF = 32'h0;
            #1;
            chk1($sformatf("vec%0d.taken", k), TakenE, vecs[k].et);
            chk1($sformatf("vec%0d.mispredict", k), MispredictE, vecs[k].em);
            chk32($sformatf("vec%0d.redirect", k), RedirectPCE, vecs[k].er);
            chk1($sformatf("vec%0d.illegal", k), IllegalCondE, vecs[k].ei);
            step();
        end

        for (int n = 0; n < 2000; n++) begin
            logic [31:0] pce;
            idle();
            pce = (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
            PCE = pce;
            PCPlus4E = pce + 32'd4;
            ValidE = ($urandom % 8) != 0;
            if (pce[5:2] == 4'hF) begin
                JumpE = 1;
            end else begin
                BranchE = ($urandom % 4) != 0;
            end
            CondE = (($urandom % 4) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            if (($urandom % 3) == 0) CondE = 4'($urandom_range(10, 11));
            ALUFlags = 4'($urandom);
            PCTargetE = 32'h1000 + 32'($urandom_range(0, 3) * 4);
            PredTakenE = $urandom % 2;
            PredTargetE = ($urandom % 2) ? PCTargetE : 32'h1000 + 32'($urandom_range(0, 3) * 4);
            PCF = ($urandom % 2) ? pce
                                 : (32'($urandom_range(0, 2)) << 6) | (32'($urandom_range(0, 15)) << 2);
`ifdef RV_BRANCH_PRED_PERF_EN
            PerfClr = ($urandom % 50) == 0;
`endif
            step();
        end

        // Reset asserted while an allocating update is on the inputs.
        idle();
        ValidE = 1; BranchE = 1; CondE = 4'b0000; ALUFlags = 4'b0100;
        PCE = 32'h80; PCTargetE = 32'h123C; PCPlus4E = 32'h84; PCF = 32'h80;
        #2 reset_n = 0;
        @(posedge clk);
        @(negedge clk);
        idle();
        reset_n = 1;
        model_reset();
        probe("midreset.0x80", 32'h80, 0, 32'h0);
        probe("midreset.0x440", 32'h440, 0, 32'h0);
        step();

`ifdef RV_BRANCH_PRED_PERF_EN
        br(32'h40, 1, 32'h80);
        br(32'h40, 0, 32'h80);
        #1;
        chk32("perf.branches", BranchCnt, 32'd2);
        chk32("perf.mispredicts", MispredCnt, 32'd1);
        idle();
        ValidE = 1; BranchE = 1; CondE = 4'b0000; ALUFlags = 4'b0100;
        PCE = 32'h40; PCTargetE = 32'h99C; PCPlus4E = 32'h44; PCF = 32'h40;
        PerfClr = 1;
        step();
        idle();
        #1;
        chk32("perf.clr_branches", BranchCnt, 32'd0);
        chk32("perf.clr_mispredicts", MispredCnt, 32'd0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
